// File: rtl/mileage_display_scan.sv
// Mileage to eight-digit multiplexed seven-segment display: sequential double-dabble
// conversion plus digit scanner. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module mileage_display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_now,
  input  logic [26:0] record,
  output logic        busy,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [26:0] MAX_MILES = 27'd99_999_999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state_q;
  logic [26:0]        last_raw_q;
  logic [26:0]        bin_q;
  logic [31:0]        bcd_q;
  logic [31:0]        bcd_d;
  logic [31:0]        disp_q;
  logic [4:0]         cnt_q;
  logic               busy_q;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         idx_q;
  logic [7:0]         seg_out_q;
  logic [7:0]         seg_en_q;
  logic [7:0]         seg_out_d;
  logic [7:0]         seg_en_d;
  logic [26:0]        rec_sat;
  logic [31:0]        disp_sh;
  logic               blank;

  function automatic logic [7:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 8'hFC;
      4'd1:    decode = 8'h60;
      4'd2:    decode = 8'hDA;
      4'd3:    decode = 8'hF2;
      4'd4:    decode = 8'h66;
      4'd5:    decode = 8'hB6;
      4'd6:    decode = 8'hBE;
      4'd7:    decode = 8'hE0;
      4'd8:    decode = 8'hFE;
      4'd9:    decode = 8'hF6;
      default: decode = 8'h00;
    endcase
  endfunction

  // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_d[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  assign rec_sat = (record > MAX_MILES) ? MAX_MILES : record;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      last_raw_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (record != last_raw_q) begin
            last_raw_q <= record;
            bin_q      <= rec_sat;
            bcd_q      <= '0;
            cnt_q      <= '0;
            state_q    <= SHIFT;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_d[30:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 5'd1;
          if (cnt_q == 5'd26) state_q <= LOAD;
        end
        LOAD: begin
          disp_q  <= bcd_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign disp_sh = disp_q >> {idx_q, 2'b00};

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above position 0 is dark when it and every higher digit are zero.
  assign blank = (idx_q != 3'd0) && (disp_sh == 32'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_en_d  = 8'h00;
    seg_out_d = 8'h00;
    if (power_now) begin
      seg_en_d  = 8'h01 << idx_q;
      seg_out_d = blank ? 8'h00 : decode(disp_sh[3:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en_q  <= 8'h00;
      seg_out_q <= 8'h00;
    end else begin
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end

  assign busy    = busy_q;
  assign seg_out = seg_out_q;
  assign seg_en  = seg_en_q;

endmodule

// File: tb/tb_mileage_display_scan.sv
// Bench for mileage_display_scan: decimal-arithmetic display model plus scenario tasks.
module tb_mileage_display_scan;

  localparam int D = 4;
  localparam int MAXV = 99_999_999;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        power_now = 1'b1;
  logic [26:0] record = '0;
  logic        busy;
  logic [7:0]  seg_out;
  logic [7:0]  seg_en;

  int checks = 0;
  int errors = 0;

  mileage_display_scan #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst(rst), .power_now(power_now), .record(record),
    .busy(busy), .seg_out(seg_out), .seg_en(seg_en)
  );

  always #5 clk = ~clk;

  // Reference model: the shown value is plain decimal arithmetic; a conversion is a
  // 28-edge countdown after which the saturated captured value becomes visible.
  logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  int          m_k, m_left, m_disp, m_pend;
  logic [26:0] m_last;
  logic [7:0]  m_seg_en, m_seg_out;
  logic        m_busy;
  assign m_busy = (m_left != 0);

  function automatic int idx_of(input int k);
    return (k / D) % 8;
  endfunction

  function automatic logic [7:0] pattern(input int val, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx >= 1 && val < p) return 8'h00;
`endif
    return seg_tab[(val / p) % 10];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_left <= 0; m_disp <= 0; m_pend <= 0; m_last <= '0;
      m_seg_en <= 8'h00; m_seg_out <= 8'h00;
    end else begin
      m_seg_en  <= power_now ? 8'(1 << idx_of(m_k)) : 8'h00;
      m_seg_out <= power_now ? pattern(m_disp, idx_of(m_k)) : 8'h00;
      m_k <= m_k + 1;
      if (m_left == 0) begin
        if (record != m_last) begin
          m_last <= record;
          m_pend <= (int'(record) > MAXV) ? MAXV : int'(record);
          m_left <= 28;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) m_disp <= m_pend;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (seg_en !== 8'h00 || seg_out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: en=%h out=%h busy=%b want 00 00 0", seg_en, seg_out, busy);
    end
    power_now = 1'b1; record = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (seg_en !== 8'h01 || seg_out !== 8'hFC || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_edge: en=%h out=%h busy=%b want 01 FC 0", seg_en, seg_out, busy);
    end
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg_en !== 8'h00 || seg_out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: en=%h out=%h busy=%b want 00 00 0", seg_en, seg_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8 * D; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || seg_en !== m_seg_en || seg_out !== 8'hFC) begin
        errors++;
        $display("FAIL reset_frame c=%0d: en=%h out=%h busy=%b want %h FC 0", c, seg_en, seg_out, busy, m_seg_en);
      end
    end
  endtask

  task automatic test_conversion();
    logic [7:0] exp_q [$];
    int cnt, guard;
    logic [7:0] prev;
    exp_q = '{8'hFE, 8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60};
    @(negedge clk);
    record = 27'd12_345_678;
    @(negedge clk);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 28) begin
      errors++;
      $display("FAIL conv_busy_len: got %0d cycles want 28", cnt);
    end
    prev = seg_en; guard = 0;
    @(negedge clk);
    while (!(seg_en === 8'h01 && prev !== 8'h01) && guard < 200) begin
      prev = seg_en; guard++;
      @(negedge clk);
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL conv_frame_start: seg_en never reached 01");
    end
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < D; c++) begin
        checks++;
        if (seg_en !== 8'(1 << d) || seg_out !== exp_q[d]) begin
          errors++;
          $display("FAIL conv_digit d=%0d c=%0d: en=%h out=%h want %h %h", d, c, seg_en, seg_out, 8'(1 << d), exp_q[d]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    record = 27'd120_000_000;
    repeat (30) @(negedge clk);
    for (int c = 0; c < 8 * D + 20; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || seg_out !== 8'hF6 || seg_en !== m_seg_en) begin
        errors++;
        $display("FAIL saturation c=%0d: busy=%b out=%h en=%h want 0 F6 %h", c, busy, seg_out, seg_en, m_seg_en);
      end
    end
  endtask

  task automatic test_change_while_busy();
    @(negedge clk);
    record = 27'd500;
    repeat (2) @(negedge clk);
    record = 27'd600;
    for (int c = 0; c < 90 + 8 * D; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== m_busy || seg_en !== m_seg_en || seg_out !== m_seg_out) begin
        errors++;
        $display("FAIL busy_change c=%0d: busy=%b en=%h out=%h want %b %h %h", c, busy, seg_en, seg_out, m_busy, m_seg_en, m_seg_out);
      end
    end
  endtask

  task automatic test_power_off();
    @(negedge clk);
    power_now = 1'b0;
    @(negedge clk);
    checks++;
    if (seg_en !== 8'h00 || seg_out !== 8'h00) begin
      errors++;
      $display("FAIL power_off_edge: en=%h out=%h want 00 00", seg_en, seg_out);
    end
    record = 27'd31_415_926;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (seg_en !== 8'h00 || seg_out !== 8'h00 || busy !== m_busy) begin
        errors++;
        $display("FAIL power_off_hold c=%0d: en=%h out=%h busy=%b want 00 00 %b", c, seg_en, seg_out, busy, m_busy);
      end
    end
    power_now = 1'b1;
    for (int c = 0; c < 8 * D; c++) begin
      @(negedge clk);
      checks++;
      if (seg_en !== m_seg_en || seg_out !== m_seg_out) begin
        errors++;
        $display("FAIL power_resume c=%0d: en=%h out=%h want %h %h", c, seg_en, seg_out, m_seg_en, m_seg_out);
      end
    end
  endtask

  task automatic test_small_values();
    int vals [3] = '{405, 0, 7};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      record = 27'(vals[v]);
      for (int c = 0; c < 30 + 8 * D; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== m_busy || seg_en !== m_seg_en || seg_out !== m_seg_out) begin
          errors++;
          $display("FAIL small_val v=%0d c=%0d: busy=%b en=%h out=%h want %b %h %h", vals[v], c, busy, seg_en, seg_out, m_busy, m_seg_en, m_seg_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    @(negedge clk);
    record = 27'd88_888_888;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40 + 8 * D; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== m_busy || seg_en !== m_seg_en || seg_out !== m_seg_out) begin
        errors++;
        $display("FAIL reset_midconv c=%0d: busy=%b en=%h out=%h want %b %h %h", c, busy, seg_en, seg_out, m_busy, m_seg_en, m_seg_out);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       record = 27'($urandom_range(0, 999));
        1:       record = 27'($urandom_range(100_000_000, 134_217_727));
        2:       record = record;
        default: record = 27'($urandom_range(0, 99_999_999));
      endcase
      power_now = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        checks++;
        if (busy !== m_busy || seg_en !== m_seg_en || seg_out !== m_seg_out) begin
          errors++;
          $display("FAIL random t=%0d c=%0d rec=%0d: busy=%b en=%h out=%h want %b %h %h", t, c, record, busy, seg_en, seg_out, m_busy, m_seg_en, m_seg_out);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_conversion();
    test_saturation();
    test_change_while_busy();
    test_power_off();
    test_small_values();
    test_reset_mid_conversion();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
